// File: rtl/sc_hex_display_if.sv
// Port bundle between the CPU output-port words and the 8-digit seven-segment display.
// The master drives the port words and the source select; the display (slave) drives the digit outputs.
interface sc_hex_display_if;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [31:0] port_c;
  logic [1:0]  sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;

  modport master (
    output port_a, port_b, port_c, sel,
    input  an, seg, dp, busy, ovf
  );

  modport slave (
    input  port_a, port_b, port_c, sel,
    output an, seg, dp, busy, ovf
  );
endinterface

// File: rtl/sc_hex_display.sv
// 8-digit multiplexed common-anode display of one selected output-port word.
// Default build shows hex digits; defining SC_HEX_DISP_BCD_EN adds a sequential double-dabble converter for decimal digits.
module sc_hex_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic              clock,
  input logic              resetn,
  sc_hex_display_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [31:0]   disp_q;
  logic [31:0]   hold_w;
  logic [31:0]   src;
  logic          ovf_w;
  logic          dash;

  assign dash = (bus.sel == 2'b11);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    src = hold_w;
    case (bus.sel)
      2'b00:   src = bus.port_a;
      2'b01:   src = bus.port_b;
      2'b10:   src = bus.port_c;
      default: src = hold_w;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

`ifdef SC_HEX_DISP_BCD_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e       state_q;
  logic [31:0]  cap_q;
  logic [71:0]  sr_q;
  logic [4:0]   cnt_q;
  logic         busy_q;
  logic         ovf_q;

  // One double-dabble step: correct the ten BCD nibbles above the binary field, then shift.
  function automatic logic [71:0] dd_step(input logic [71:0] s);
    logic [71:0] t;
    t = s;
    for (int n = 0; n < 10; n++) begin
      if (t[32 + 4*n +: 4] >= 4'd5) t[32 + 4*n +: 4] = t[32 + 4*n +: 4] + 4'd3;
    end
    return {t[70:0], 1'b0};
  endfunction

  assign hold_w = cap_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (src != cap_q) begin
            cap_q   <= src;
            sr_q    <= {40'b0, src};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr_q  <= dd_step(sr_q);
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_DONE;
        end
        S_DONE: begin
          disp_q  <= sr_q[63:32];
          ovf_q   <= |sr_q[71:64];
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign ovf_w    = ovf_q;
`else
  // With sel = 11 the source is the shown value itself, so the display simply holds.
  assign hold_w = disp_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) disp_q <= '0;
    else         disp_q <= src;
  end

  assign bus.busy = 1'b0;
  assign ovf_w    = 1'b0;
`endif

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [3:0] nib;
  logic       blank;
  logic [7:0] an_d,  an_q;
  logic [6:0] seg_d, seg_q;
  logic       dp_d,  dp_q;

  // A digit is blanked when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    blank = BLANK_LZ && (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);
    an_d  = ~(8'd1 << idx_q);
    seg_d = hex_seg(nib);
    if (dash)       seg_d = 7'h3F;
    else if (blank) seg_d = 7'h7F;
    dp_d  = ~((idx_q == 3'd0) && ovf_w && !dash);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      an_q  <= 8'hFE;
      seg_q <= 7'h40;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.ovf = ovf_w;

endmodule

// File: tb/tb_sc_hex_display.sv
// Self-checking bench for sc_hex_display: directed and random port words against an arithmetic display model.
// Builds with or without SC_HEX_DISP_BCD_EN; the model follows the same macro.
module tb_sc_hex_display;
  localparam int SCAN_DIV = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  sc_hex_display_if bus ();

  sc_hex_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  longint unsigned exp_val  = 0;
  bit              exp_ovf  = 1'b0;
  bit              exp_dash = 1'b0;
  logic [31:0]     cap_m    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_seg(input int i);
    longint unsigned v, upper, scale;
    int nib;
`ifdef SC_HEX_DISP_BCD_EN
    v = exp_val % 64'd100000000;
    scale = 1;
    for (int k = 0; k < i; k++) scale = scale * 10;
    upper = v / scale;
    nib = int'(upper % 10);
`else
    v = exp_val;
    upper = v >> (4 * i);
    nib = int'(upper & 15);
`endif
    if (exp_dash) return 7'h3F;
    if (i > 0 && upper == 0) return 7'h7F;
    return seg_tab[nib];
  endfunction

  // Sample n clocks; the active digit is recovered from an and its segments checked.
  task automatic scan(input string tag, input int n, input bit chk_flags);
    for (int c = 0; c < n; c++) begin
      int idx;
      logic [7:0] pat;
      @(negedge clock);
      idx = -1;
      for (int i = 0; i < 8; i++) begin
        pat = ~(8'd1 << i);
        if (bus.an === pat) idx = i;
      end
      check({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check($sformatf("%s_seg%0d", tag, idx), 32'(bus.seg), 32'(model_seg(idx)));
        check($sformatf("%s_dp%0d", tag, idx), 32'(bus.dp),
              32'((!exp_dash && idx == 0 && exp_ovf) ? 1'b0 : 1'b1));
      end
      if (chk_flags) begin
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
      end
    end
  endtask

  // Call right after inputs change at a negedge; measures the busy pulse.
  task automatic wait_conv(input string tag);
    int t;
    int cnt;
    t = 0;
    cnt = 0;
    do begin
      @(negedge clock);
      t++;
    end while (bus.busy !== 1'b1 && t < 4);
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    check({tag, "_busy_len"}, 32'(cnt), 32'd33);
    @(negedge clock);
  endtask

  task automatic apply(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input string tag);
    logic [31:0] src;
    @(negedge clock);
    bus.sel    = s;
    bus.port_a = a;
    bus.port_b = b;
    bus.port_c = c;
    src = (s == 2'd0) ? a : (s == 2'd1) ? b : (s == 2'd2) ? c : 32'(exp_val);
`ifdef SC_HEX_DISP_BCD_EN
    if (s != 2'b11 && src != cap_m) begin
      wait_conv(tag);
      cap_m   = src;
      exp_val = longint'(src);
      exp_ovf = (longint'(src) > 64'd99999999);
    end else begin
      repeat (2) @(negedge clock);
    end
`else
    repeat (2) @(negedge clock);
    if (s != 2'b11) exp_val = longint'(src);
    exp_ovf = 1'b0;
`endif
    exp_dash = (s == 2'b11);
    scan(tag, 34, 1'b1);
  endtask

  initial begin
    bus.port_a = '0;
    bus.port_b = '0;
    bus.port_c = '0;
    bus.sel    = 2'b00;
    resetn     = 1'b0;

    repeat (10) @(negedge clock);
    check("rst_an",   32'(bus.an),   32'hFE);
    check("rst_seg",  32'(bus.seg),  32'h40);
    check("rst_dp",   32'(bus.dp),   32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);

    resetn = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      logic [7:0] exp_an;
      @(negedge clock);
      exp_an = ~(8'd1 << (((k - 1) / SCAN_DIV) % 8));
      check($sformatf("scan_an_k%0d", k), 32'(bus.an), 32'(exp_an));
    end

    apply(2'b00, 32'h1234ABCD, 32'h0, 32'h0, "hex_1234abcd");
    apply(2'b01, 32'h0, 32'h00BC614E, 32'h0, "val_12345678");
    apply(2'b10, 32'h0, 32'h0, 32'hFFFFFFFF, "val_ffffffff");
    apply(2'b00, 32'd5, 32'h0, 32'h0, "blank_5");
    apply(2'b11, 32'd7, 32'h0, 32'h0, "dash");
    apply(2'b00, 32'h0, 32'h0, 32'h0, "zero");

    for (int r = 0; r < 8; r++) begin
      logic [1:0]  s;
      logic [31:0] a, b, c;
      s = 2'($urandom_range(0, 3));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      c = $urandom;
      apply(s, a, b, c, $sformatf("rand%0d", r));
    end

`ifdef SC_HEX_DISP_BCD_EN
    begin
      int cnt;
      int t;
      apply(2'b00, 32'd9, 32'h0, 32'h0, "pre_100");

      @(negedge clock);
      bus.port_a = 32'd100;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (bus.busy !== 1'b1 && t < 4);
      check("chg_busy_rise", 32'(bus.busy), 32'd1);
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 100) begin
        if (cnt == 11) bus.port_a = 32'd200;
        cnt++;
        @(negedge clock);
      end
      check("chg_busy_len1", 32'(cnt), 32'd33);
      exp_val = 100;
      exp_ovf = 1'b0;
      cap_m   = 32'd200;
      @(negedge clock);
      check("chg_second_busy", 32'(bus.busy), 32'd1);
      scan("chg_show100", 20, 1'b0);
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 100) begin
        cnt++;
        @(negedge clock);
      end
      check("chg_busy_fall2", 32'(bus.busy), 32'd0);
      exp_val = 200;
      @(negedge clock);
      scan("chg_show200", 34, 1'b1);

      @(negedge clock);
      bus.port_a = 32'd300;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (bus.busy !== 1'b1 && t < 4);
      check("mid_busy_rise", 32'(bus.busy), 32'd1);
      repeat (5) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_an",   32'(bus.an),   32'hFE);
      check("mid_rst_seg",  32'(bus.seg),  32'h40);
      check("mid_rst_dp",   32'(bus.dp),   32'd1);
      exp_val = 0;
      exp_ovf = 1'b0;
      cap_m   = '0;
      repeat (3) @(negedge clock);
      check("mid_rst_hold_seg", 32'(bus.seg), 32'h40);
      resetn = 1'b1;
      wait_conv("after_rst");
      cap_m   = 32'd300;
      exp_val = 300;
      scan("after_rst_300", 34, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_hex_display.md
Name: sc_hex_display

Overview:
Downstream consumer of the data-memory I/O output ports. Takes the three 32-bit output-port words and selects one for an 8-digit multiplexed common-anode seven-segment display. Digits show either hex nibbles or decimal (sequential double-dabble binary-to-BCD) with leading-zero blanking. This is the program-visible numeric display for single-cycle CPU demos.

Parameters:
SCAN_DIV, 50000, clocks per digit-scan step (minimum 2); benches use 4
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
port_a  in  32  connected to out_port0
port_b  in  32  connected to out_port1
port_c  in  32  connected to out_port2
sel  in  2  00 = port_a, 01 = port_b, 10 = port_c, 11 = dash pattern
an  out  8  digit enables, active-low; bit i = digit i (digit 0 rightmost)
seg  out  7  segments, active-low; seg[0] = a … seg[6] = g
dp  out  1  decimal point, active-low
busy  out  1  BCD conversion in progress
ovf  out  1  decimal value exceeds 99999999

Behaviour:
- Reset: clock and reset are as stated above (single clock, asynchronous active-low reset). Async assert clears cap, disp, digit index, prescaler, FSM = IDLE, busy = 0, ovf = 0. Outputs go to an = 8'hFE, seg = 7'h40, dp = 1. Reset mid-conversion aborts it; no partial result reaches disp.
- Source value: src = the port chosen by sel. sel = 11 keeps src = cap, so no update is triggered.
- Hex mode (macro off): disp <= src every clock, giving 1-clock latency. busy and ovf stay 0.
- BCD mode FSM (macro on):
  - IDLE: if src != cap, then cap <= src, shift register <= {40'b0, src}, busy <= 1, go to SHIFT.
  - SHIFT: 32 clocks. Each clock, add 3 to every BCD nibble >= 5, then shift left 1. Counter 0..31.
  - DONE: disp <= low 8 BCD digits; ovf <= (upper 2 digits != 0); busy <= 0; go to IDLE.
  - busy is high for exactly 33 clocks. disp updates 34 clocks after a src change.
  - A src change while busy is ignored until IDLE re-compares it, so disp always converges to the final src.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the terminal count, the digit index increments mod 8 (7 wraps to 0).
  - an, seg and dp are registered and follow the index/disp with 1-clock latency.
  - an = ~(1 << idx).
- Decode (hex, seg[6:0]): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Blanking: when BLANK_LZ = 1 and idx > 0 and nibbles idx..7 of disp are all zero, seg = 7'h7F.
- sel = 11: every digit shows seg = 7'h3F (dash). dp = 1.
- dp = 0 only on digit 0 when ovf = 1. Otherwise dp = 1.
- A sel change takes effect on the next clock (hex mode) or via the FSM (BCD mode). The scan position is not disturbed.

Optional Feature:
SC_HEX_DISP_BCD_EN
- Defined: BCD FSM, busy and ovf are implemented; digits are decimal.
- Undefined: no FSM; disp tracks src directly; busy = 0 and ovf = 0 constant; hex digits shown.

Test Plan:
1. Reset with SCAN_DIV=4, hold 10 clocks -> an=FE, seg=40, dp=1, busy=0, ovf=0. Release -> an steps FE, FD, FB … every 4 clocks and wraps to FE after 7F.
2. Hex build, sel=00, port_a=32'h1234ABCD -> across one scan cycle digit0..7 seg = 21, 46, 03, 08, 19, 30, 24, 79.
3. BCD build, sel=01, port_b=32'h00BC614E (12345678) -> busy high 33 clocks; digits0..7 = 8,7,6,5,4,3,2,1 (00,78,02,12,19,30,24,79); ovf=0.
4. BCD build, sel=10, port_c=32'hFFFFFFFF -> digits show 94967295; ovf=1; dp=0 only while an=FE.
5. port_a=5, BLANK_LZ=1 -> digit0 seg=12, digits1-7 seg=7F. sel=11 -> all digits 3F, dp=1.
6. BCD build: change port_a from 100 to 200 at SHIFT clock 10 -> first conversion finishes showing 100, then a second 33-clock busy shows 200. Assert resetn mid-SHIFT -> busy=0 immediately, disp=0.
